// File: rtl/dispense_controller.sv
// Valve controller for one fill: accepts a clamped unit count, opens the valve for
// amount x CLOCKS_PER_UNIT cup-present cycles, pauses without a cup, and aborts on cancel or timeout.
module dispense_controller #(
    parameter int AMOUNT_WIDTH    = 32,
    parameter int CLOCKS_PER_UNIT = 1000,
    parameter int MAX_AMOUNT      = 999,
    parameter int HOLD_TIMEOUT    = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    input  logic                    start,
    output logic                    ready,
    input  logic                    cancel,
    input  logic                    cup_present,
    output logic                    valve,
    output logic                    busy,
    output logic [AMOUNT_WIDTH-1:0] remaining,
    output logic [AMOUNT_WIDTH-1:0] dispensed,
    output logic                    done,
    output logic                    aborted
);

    localparam int TICK_W = (CLOCKS_PER_UNIT > 1) ? $clog2(CLOCKS_PER_UNIT) : 1;
    localparam int HOLD_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(CLOCKS_PER_UNIT - 1);
    localparam logic [HOLD_W-1:0]       HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
    localparam logic [AMOUNT_WIDTH-1:0] AMT_MAX   = AMOUNT_WIDTH'(MAX_AMOUNT);
    localparam logic [AMOUNT_WIDTH-1:0] AMT_ONE   = AMOUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [TICK_W-1:0]       r_tick;
    logic [HOLD_W-1:0]       r_hold;
    logic [AMOUNT_WIDTH-1:0] r_remaining;
    logic [AMOUNT_WIDTH-1:0] r_dispensed;
    logic                    r_aborted;

    logic [AMOUNT_WIDTH-1:0] w_latched;
    logic                    w_unit_done;
    logic                    w_hold_expired;

    assign w_latched      = (amount > AMT_MAX) ? AMT_MAX : amount;
    assign w_unit_done    = cup_present && (r_tick == TICK_LAST);
    assign w_hold_expired = !cup_present && (r_hold == HOLD_LAST);

    assign valve     = (r_state == S_FILL) && cup_present;
    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state == S_FILL) || (r_state == S_HOLD);
    assign done      = (r_state == S_DONE);
    assign remaining = r_remaining;
    assign dispensed = r_dispensed;
    assign aborted   = r_aborted;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_latched == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (cancel) begin
                    w_next = S_DONE;
                end else if (!cup_present) begin
                    w_next = S_HOLD;
                end else if (w_unit_done && (r_remaining == AMT_ONE)) begin
                    w_next = S_DONE;
                end
            end
            S_HOLD: begin
                if (cancel || w_hold_expired) begin
                    w_next = S_DONE;
                end else if (cup_present) begin
                    w_next = S_FILL;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Cancel is checked first in FILL so a coincident unit completion leaves the counts untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tick      <= '0;
            r_hold      <= '0;
            r_remaining <= '0;
            r_dispensed <= '0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= w_latched;
                        r_dispensed <= '0;
                        r_aborted   <= 1'b0;
                        r_tick      <= '0;
                        r_hold      <= '0;
                    end
                end
                S_FILL: begin
                    if (cancel) begin
                        r_aborted <= 1'b1;
                    end else if (!cup_present) begin
                        r_hold <= '0;
                    end else if (w_unit_done) begin
                        r_tick      <= '0;
                        r_remaining <= r_remaining - AMT_ONE;
                        r_dispensed <= r_dispensed + AMT_ONE;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cancel || w_hold_expired) begin
                        r_aborted <= 1'b1;
                    end else if (cup_present) begin
                        r_hold <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: directed vector table, multi-cycle corner sequences,
// and random stimulus against a tick-budget reference model.
module tb_dispense_controller;

    localparam int AW   = 32;
    localparam int CPU  = 4;
    localparam int MAXA = 999;
    localparam int HT   = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] amount;
    logic          start;
    logic          ready;
    logic          cancel;
    logic          cup_present;
    logic          valve;
    logic          busy;
    logic [AW-1:0] remaining;
    logic [AW-1:0] dispensed;
    logic          done;
    logic          aborted;

    int tests = 0;
    int fails = 0;

    dispense_controller #(
        .AMOUNT_WIDTH   (AW),
        .CLOCKS_PER_UNIT(CPU),
        .MAX_AMOUNT     (MAXA),
        .HOLD_TIMEOUT   (HT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .amount     (amount),
        .start      (start),
        .ready      (ready),
        .cancel     (cancel),
        .cup_present(cup_present),
        .valve      (valve),
        .busy       (busy),
        .remaining  (remaining),
        .dispensed  (dispensed),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic rst, st, cn, cup;
        int   amt;
        logic e_ready, e_valve, e_busy, e_done, e_ab;
        int   e_rem, e_disp;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic rst, st, cn, cup, input int amt,
                       input logic er, ev, eb, ed, ea, input int erem, edisp);
        vecs[nvec] = '{rst, st, cn, cup, amt, er, ev, eb, ed, ea, erem, edisp};
        nvec++;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a fill is a budget of valve-open cycles; unit counts derive from it.
    int m_mode = 0;        // 0 idle, 1 filling, 2 finishing
    bit m_paused = 0;
    int m_ticks_left = 0;
    int m_lat = 0;
    int m_streak = 0;
    bit m_ab = 0;

    function automatic int m_remaining();
        return (m_ticks_left + CPU - 1) / CPU;
    endfunction

    task automatic model_step();
        if (!reset) begin
            m_mode = 0; m_paused = 0; m_ticks_left = 0; m_lat = 0; m_streak = 0; m_ab = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_lat = (amount > MAXA) ? MAXA : int'(amount);
                m_ticks_left = m_lat * CPU;
                m_ab = 0; m_paused = 0; m_streak = 0;
                m_mode = (m_lat == 0) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (cancel) begin
                m_mode = 2; m_ab = 1;
            end else if (!m_paused) begin
                if (cup_present) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) m_mode = 2;
                end else begin
                    m_paused = 1; m_streak = 0;
                end
            end else if (cup_present) begin
                m_paused = 0;
            end else begin
                m_streak++;
                if (m_streak == HT) begin
                    m_mode = 2; m_ab = 1;
                end
            end
        end else begin
            m_mode = 0;
        end
    endtask

    int vh, gap_left, gap_valve, bsy_absent, c;
    bit gap_used, seen;

    initial begin
        reset = 1'b0; start = 1'b0; cancel = 1'b0; cup_present = 1'b1; amount = '0;
        repeat (2) @(negedge clock);

        // Test 1: three-unit fill with cup present.
        add(0,0,0,1,0, 1,0,0,0,0, 0,0);
        add(1,1,0,1,3, 1,0,0,0,0, 0,0);
        for (int k = 0; k < 12; k++) add(1,0,0,1,0, 0,1,1,0,0, 3 - k / 4, k / 4);
        add(1,0,0,1,0, 0,0,0,1,0, 0,3);
        add(1,0,0,1,0, 1,0,0,0,0, 0,3);
        // Zero amount, then clamping and cancel.
        add(1,1,0,1,0, 1,0,0,0,0, 0,3);
        add(1,0,0,1,0, 0,0,0,1,0, 0,0);
        add(1,0,0,1,0, 1,0,0,0,0, 0,0);
        add(1,1,0,1,1200, 1,0,0,0,0, 0,0);
        add(1,0,0,1,0, 0,1,1,0,0, 999,0);
        add(1,0,1,1,0, 0,1,1,0,0, 999,0);
        add(1,0,0,1,0, 0,0,0,1,1, 999,0);
        add(1,0,1,1,0, 1,0,0,0,1, 999,0);
        add(1,0,0,1,0, 1,0,0,0,1, 999,0);
        // Cancel on the very cycle the first unit completes.
        add(1,1,0,1,3, 1,0,0,0,1, 999,0);
        for (int k = 0; k < 3; k++) add(1,0,0,1,0, 0,1,1,0,0, 3,0);
        add(1,0,1,1,0, 0,1,1,0,0, 3,0);
        add(1,0,0,1,0, 0,0,0,1,1, 3,0);
        add(1,0,0,1,0, 1,0,0,0,1, 3,0);
        // Reset mid-fill, then reset while start is high.
        add(1,1,0,1,2, 1,0,0,0,1, 3,0);
        add(1,0,0,1,0, 0,1,1,0,0, 2,0);
        add(1,0,0,1,0, 0,1,1,0,0, 2,0);
        add(0,0,0,1,0, 0,1,1,0,0, 2,0);
        add(1,0,0,1,0, 1,0,0,0,0, 0,0);
        add(0,1,0,1,5, 1,0,0,0,0, 0,0);
        add(1,0,0,1,0, 1,0,0,0,0, 0,0);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clock);
            reset = vecs[i].rst; start = vecs[i].st; cancel = vecs[i].cn;
            cup_present = vecs[i].cup; amount = AW'(vecs[i].amt);
            #1;
            tests++;
            if ({ready, valve, busy, done, aborted, remaining, dispensed} !==
                {vecs[i].e_ready, vecs[i].e_valve, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ab,
                 AW'(vecs[i].e_rem), AW'(vecs[i].e_disp)}) begin
                fails++;
                $display("FAIL vec%0d: rdy/vlv/bsy/don/abt=%b%b%b%b%b rem=%0d disp=%0d expected %b%b%b%b%b rem=%0d disp=%0d",
                         i, ready, valve, busy, done, aborted, remaining, dispensed,
                         vecs[i].e_ready, vecs[i].e_valve, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ab,
                         vecs[i].e_rem, vecs[i].e_disp);
            end
        end

        // Cup removed for 5 cycles after 6 valve-open cycles: total open time still 12.
        @(negedge clock);
        reset = 1; start = 1; amount = 3; cancel = 0; cup_present = 1;
        vh = 0; gap_left = 0; gap_valve = 0; gap_used = 0; seen = 0;
        for (c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            start = 0;
            if (vh == 6 && !gap_used) begin gap_left = 5; gap_used = 1; end
            cup_present = (gap_left == 0);
            #1;
            if (valve) begin
                vh++;
                if (gap_left > 0) gap_valve++;
            end
            if (gap_left > 0) gap_left--;
            seen = done;
        end
        check("pause_done_seen", seen, 1);
        check("pause_valve_in_gap", gap_valve, 0);
        check("pause_valve_total", vh, 12);
        check("pause_dispensed", dispensed, 3);
        check("pause_aborted", aborted, 0);

        // Cancel after 6 valve-open cycles.
        @(negedge clock);
        start = 1; amount = 3; cup_present = 1;
        vh = 0; seen = 0;
        for (c = 0; c < 50 && vh < 6; c++) begin
            @(negedge clock);
            start = 0;
            #1;
            if (valve) vh++;
        end
        @(negedge clock);
        cancel = 1;
        @(negedge clock);
        cancel = 0;
        #1;
        check("cancel_done", done, 1);
        check("cancel_counts", {aborted, dispensed, remaining}, {1'b1, AW'(1), AW'(2)});

        // Cup kept away: abort after HT hold cycles; start held throughout must not queue.
        @(negedge clock);
        start = 1; amount = 3; cup_present = 1;
        vh = 0; bsy_absent = 0; seen = 0;
        for (c = 0; c < 100 && !seen; c++) begin
            @(negedge clock);
            start = 1;
            cup_present = (vh < 2);
            #1;
            if (valve) vh++;
            if (busy && !cup_present) bsy_absent++;
            seen = done;
        end
        check("timeout_done_seen", seen, 1);
        // One FILL cycle noticing the empty sensor, then HT cycles in HOLD.
        check("timeout_absent_cycles", bsy_absent, 1 + HT);
        check("timeout_counts", {aborted, dispensed, remaining}, {1'b1, AW'(0), AW'(3)});
        @(negedge clock);
        start = 0; cup_present = 1;
        #1;
        check("timeout_ready", ready, 1);
        @(negedge clock);
        #1;
        check("no_queued_start", {ready, busy, valve}, 3'b100);

        // Random stimulus against the reference model.
        @(negedge clock);
        reset = 0; start = 0; cancel = 0;
        @(posedge clock);
        model_step();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 5) == 0);
            cancel = ($urandom_range(0, 39) == 0);
            if (cup_present) cup_present = ($urandom_range(0, 9) != 0);
            else cup_present = ($urandom_range(0, 6) == 0);
            c = $urandom_range(0, 15);
            amount = (c == 15) ? AW'(1200 + $urandom_range(0, 5)) : AW'(c % 7);
            #1;
            tests++;
            if ({ready, busy, done, valve, aborted, remaining, dispensed} !==
                {m_mode == 0, m_mode == 1, m_mode == 2, (m_mode == 1) && !m_paused && cup_present,
                 m_ab, AW'(m_remaining()), AW'(m_lat - m_remaining())}) begin
                fails++;
                $display("FAIL rand%0d: rdy=%b bsy=%b don=%b vlv=%b abt=%b rem=%0d disp=%0d expected mode=%0d paused=%b abt=%b rem=%0d disp=%0d",
                         n, ready, busy, done, valve, aborted, remaining, dispensed,
                         m_mode, m_paused, m_ab, m_remaining(), m_lat - m_remaining());
            end
            @(posedge clock);
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
